// File: rtl/cont_mod2_decoder_pkg.sv
// Shared step-code and direction encodings for the 2-bit counter decoder.
package cont_mod2_decoder_pkg;

    // (S - prev) mod 4 maps directly onto these codes
    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STEP_UP = 2'd1,
        ILLEGAL = 2'd2,
        STEP_DN = 2'd3
    } step_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/cont_mod2_decoder_sync_ff_chain.sv
// Multi-flop synchroniser with a companion valid shift register marking
// when a genuine post-reset sample has reached the last stage.
module sync_ff_chain #(
    parameter int STAGES = 2,
    parameter int W      = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic         vld_o
);

    logic [STAGES-1:0][W-1:0] ff_q;
    logic [STAGES-1:0]        vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff_q  <= '0;
            vld_q <= '0;
        end else begin
            ff_q[0]  <= d_i;
            vld_q[0] <= 1'b1;
            for (int i = 1; i < STAGES; i++) begin
                ff_q[i]  <= ff_q[i-1];
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    assign q_o   = ff_q[STAGES-1];
    assign vld_o = vld_q[STAGES-1];

endmodule

// File: rtl/cont_mod2_decoder.sv
// Recovers direction, step pulses and a saturating signed position from an
// asynchronous 2-bit up/down counter code; flags illegal two-step jumps.
module cont_mod2_decoder
    import cont_mod2_decoder_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int POS_W       = 8
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Q1,
    input  logic                    Q0,
    input  logic                    Clr,
    output logic                    Up,
    output logic                    Dn,
    output logic                    Y,
    output logic signed [POS_W-1:0] Pos,
    output logic                    Err
);

    localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
    localparam logic [POS_W-1:0]        POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

    logic [1:0]              s;
    logic                    s_vld;
    logic [1:0]              prev_q, prev_d;
    logic                    primed_q, primed_d;
    logic                    up_q, up_d, dn_q, dn_d, y_q, y_d, err_q, err_d;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic                    illegal;
    step_e                   step;

    sync_ff_chain #(.STAGES(SYNC_STAGES), .W(2)) u_sync (
        .clk   (Clk),
        .rst   (Rst),
        .d_i   ({Q1, Q0}),
        .q_o   (s),
        .vld_o (s_vld)
    );

    assign step = step_e'(s - prev_q);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            prev_q   <= '0;
            primed_q <= 1'b0;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
            y_q      <= DIR_UP;
            pos_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            primed_q <= primed_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
            y_q      <= y_d;
            pos_q    <= pos_d;
            err_q    <= err_d;
        end
    end

    // Priming waits for the synchroniser to fill so the reset zeros are
    // never mistaken for a real counter code.
    always_comb begin
        prev_d   = prev_q;
        primed_d = primed_q;
        up_d     = 1'b0;
        dn_d     = 1'b0;
        y_d      = y_q;
        pos_d    = pos_q;
        err_d    = err_q;
        illegal  = 1'b0;
        if (s_vld) begin
            prev_d   = s;
            primed_d = 1'b1;
            if (primed_q) begin
                case (step)
                    STEP_UP: begin
                        up_d = 1'b1;
                        y_d  = DIR_UP;
                        if (pos_q != POS_MAX) pos_d = pos_q + POS_ONE;
                    end
                    STEP_DN: begin
                        dn_d = 1'b1;
                        y_d  = DIR_DN;
                        if (pos_q != POS_MIN) pos_d = pos_q - POS_ONE;
                    end
                    ILLEGAL: begin
                        illegal = 1'b1;
                        err_d   = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
        // A fresh illegal jump survives a simultaneous clear
        if (Clr) begin
            pos_d = '0;
            err_d = illegal;
        end
    end

    assign Up  = up_q;
    assign Dn  = dn_q;
    assign Y   = y_q;
    assign Pos = pos_q;
    assign Err = err_q;

endmodule

// File: tb/tb_cont_mod2_decoder.sv
// Directed bench: a cycle-exact vector table plus sequence checks on an
// 8-bit and a 4-bit position instance driven in parallel.
module tb_cont_mod2_decoder;

    logic Clk = 1'b0;
    logic Rst, Q1, Q0, Clr;
    logic up8, dn8, y8, err8, up4, dn4, y4, err4;
    logic signed [7:0] pos8;
    logic signed [3:0] pos4;

    int n_chk = 0, n_fail = 0;
    int c_up8 = 0, c_dn8 = 0, c_up4 = 0, c_dn4 = 0, c_both = 0;

    typedef struct {
        logic       rst;
        logic [1:0] q;
        logic       clr;
        logic       up, dn, y;
        int         pos;
        logic       err;
    } vec_t;
    vec_t tv[$];

    always #5 Clk = ~Clk;

    cont_mod2_decoder #(.SYNC_STAGES(2), .POS_W(8)) dut8 (
        .Clk(Clk), .Rst(Rst), .Q1(Q1), .Q0(Q0), .Clr(Clr),
        .Up(up8), .Dn(dn8), .Y(y8), .Pos(pos8), .Err(err8)
    );

    cont_mod2_decoder #(.SYNC_STAGES(2), .POS_W(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .Q1(Q1), .Q0(Q0), .Clr(Clr),
        .Up(up4), .Dn(dn4), .Y(y4), .Pos(pos4), .Err(err4)
    );

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic add(input logic r, input logic [1:0] q, input logic c,
                       input logic u, input logic d, input logic y,
                       input int p, input logic e);
        vec_t v;
        v.rst = r; v.q = q; v.clr = c; v.up = u; v.dn = d; v.y = y;
        v.pos = p; v.err = e;
        tv.push_back(v);
    endtask

    task automatic cyc(input logic r, input logic [1:0] q, input logic c);
        Rst = r; {Q1, Q0} = q; Clr = c;
        @(posedge Clk);
        #1;
        if (up8) c_up8++;
        if (dn8) c_dn8++;
        if (up4) c_up4++;
        if (dn4) c_dn4++;
        if ((up8 && dn8) || (up4 && dn4)) c_both++;
    endtask

    task automatic clr_cnt();
        c_up8 = 0; c_dn8 = 0; c_up4 = 0; c_dn4 = 0;
    endtask

    task automatic hold(input logic [1:0] q, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, q, 1'b0);
    endtask

    initial begin
        logic [1:0] c;
        Rst = 1'b1; {Q1, Q0} = 2'd2; Clr = 1'b0;

        // reset then prime on code 2: nothing may move
        for (int i = 0; i < 2; i++)  add(1, 2, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 2, 0, 0, 0, 1, 0, 0);
        // re-reset on code 0, prime
        for (int i = 0; i < 2; i++)  add(1, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++)  add(0, 0, 0, 0, 0, 1, 0, 0);
        // 0->1 : pulse exactly two edges after the change
        add(0, 1, 0, 0, 0, 1, 0, 0); add(0, 1, 0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 1, 0, 1, 1, 0); add(0, 1, 0, 0, 0, 1, 1, 0);
        // 1->2
        add(0, 2, 0, 0, 0, 1, 1, 0); add(0, 2, 0, 0, 0, 1, 1, 0);
        add(0, 2, 0, 1, 0, 1, 2, 0); add(0, 2, 0, 0, 0, 1, 2, 0);
        // 2->0 illegal: Err, no pulse, Pos/Y held
        add(0, 0, 0, 0, 0, 1, 2, 0); add(0, 0, 0, 0, 0, 1, 2, 0);
        add(0, 0, 0, 0, 0, 1, 2, 1); add(0, 0, 0, 0, 0, 1, 2, 1);
        // 0->3 wrap down
        add(0, 3, 0, 0, 0, 1, 2, 1); add(0, 3, 0, 0, 0, 1, 2, 1);
        add(0, 3, 0, 0, 1, 0, 1, 1); add(0, 3, 0, 0, 0, 0, 1, 1);
        // Clr alone
        add(0, 3, 1, 0, 0, 0, 0, 0); add(0, 3, 0, 0, 0, 0, 0, 0);
        // 3->0 step coinciding with Clr: pulse and Y kept, Pos cleared
        add(0, 0, 0, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 1, 0, 0); add(0, 0, 0, 0, 0, 1, 0, 0);
        // 0->2 illegal coinciding with Clr: Err wins
        add(0, 2, 0, 0, 0, 1, 0, 0); add(0, 2, 0, 0, 0, 1, 0, 0);
        add(0, 2, 1, 0, 0, 1, 0, 1); add(0, 2, 0, 0, 0, 1, 0, 1);
        // 2->3 up, Err sticky
        add(0, 3, 0, 0, 0, 1, 0, 1); add(0, 3, 0, 0, 0, 1, 0, 1);
        add(0, 3, 0, 1, 0, 1, 1, 1); add(0, 3, 0, 0, 0, 1, 1, 1);

        for (int i = 0; i < tv.size(); i++) begin
            cyc(tv[i].rst, tv[i].q, tv[i].clr);
            chk($sformatf("vec%0d_flags8", i), {up8, dn8, y8, err8},
                {tv[i].up, tv[i].dn, tv[i].y, tv[i].err});
            chk($sformatf("vec%0d_pos8", i), int'(pos8), tv[i].pos);
            chk($sformatf("vec%0d_flags4", i), {up4, dn4, y4, err4},
                {tv[i].up, tv[i].dn, tv[i].y, tv[i].err});
            chk($sformatf("vec%0d_pos4", i), int'(pos4), tv[i].pos);
        end

        // up sequence 0,1,2,3,0,1 including the 3->0 wrap
        cyc(1, 0, 0); cyc(1, 0, 0);
        hold(0, 4);
        clr_cnt();
        c = 2'd0;
        for (int i = 0; i < 5; i++) begin c = c + 2'd1; hold(c, 4); end
        chk("up_seq_count", c_up8, 5);
        chk("up_seq_dn", c_dn8, 0);
        chk("up_seq_pos", int'(pos8), 5);
        chk("up_seq_y", y8, 1);

        // down sequence: 7 steps from Pos=5
        clr_cnt();
        for (int i = 0; i < 7; i++) begin c = c - 2'd1; hold(c, 4); end
        chk("dn_seq_count", c_dn8, 7);
        chk("dn_seq_up", c_up8, 0);
        chk("dn_seq_pos", int'(pos8), -2);
        chk("dn_seq_y", y8, 0);

        // illegal jump 0->2 then Clr, then 2->3
        hold(2'd1, 4); hold(2'd0, 4);
        clr_cnt();
        hold(2'd2, 4);
        chk("ill_err", err8, 1);
        chk("ill_pulses", c_up8 + c_dn8, 0);
        chk("ill_pos", int'(pos8), -4);
        chk("ill_y", y8, 0);
        cyc(0, 2, 1);
        chk("ill_clr_pos", int'(pos8), 0);
        chk("ill_clr_err", err8, 0);
        clr_cnt();
        hold(2'd3, 4);
        chk("ill_after_up", c_up8, 1);
        chk("ill_after_pos", int'(pos8), 1);
        chk("ill_after_y", y8, 1);

        // saturation: 4-bit instance clamps, 8-bit instance keeps counting
        c = 2'd3;
        cyc(0, c, 1);
        clr_cnt();
        for (int i = 0; i < 10; i++) begin c = c + 2'd1; hold(c, 3); end
        chk("sat_up_cnt4", c_up4, 10);
        chk("sat_up_pos4", int'(pos4), 7);
        chk("sat_up_pos8", int'(pos8), 10);
        clr_cnt();
        for (int i = 0; i < 20; i++) begin c = c - 2'd1; hold(c, 3); end
        chk("sat_dn_cnt4", c_dn4, 20);
        chk("sat_dn_pos4", int'(pos4), -8);
        chk("sat_dn_pos8", int'(pos8), -10);
        chk("sat_dn_y4", y4, 0);

        // mid-stream reset while the input changes
        cyc(0, c, 1);
        for (int i = 0; i < 3; i++) begin c = c + 2'd1; hold(c, 4); end
        chk("mid_pre_pos", int'(pos8), 3);
        c = c + 2'd1;
        cyc(1, c, 0);
        chk("mid_rst_pos", int'(pos8), 0);
        chk("mid_rst_y", y8, 1);
        clr_cnt();
        hold(c, 5);
        chk("mid_prime_pulses", c_up8 + c_dn8, 0);
        chk("mid_prime_err", err8, 0);
        c = c + 2'd1;
        hold(c, 4);
        chk("mid_resume_up", c_up8, 1);
        chk("mid_resume_pos", int'(pos8), 1);

        chk("never_up_and_dn", c_both, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
